alu4_arbiter_seq: RTL
=====================

// Module: alu4_arbiter_seq
// PURPOSE
//   Shares one combinational 4-bit ALU between NREQ requesters. Accepts op
//   commands over valid/ready, arbitrates round-robin, and drives the ALU's
//   a/b/c/cin inputs from registers, pre-inverting b and setting cin for
//   subtract/compare. Captures the ALU outputs and returns one tagged response
//   per command over valid/ready. Sits between issue logic and the ALU instance.
// PARAMETERS
//   NREQ      2   number of requesters (2..4); IDW = $clog2(NREQ), min 1
//   ALU_WAIT  0   extra settle cycles between ISSUE and CAPTURE (0..7)
// PORTS
//   clk           in   1        clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   req_valid     in   NREQ     per-requester command valid
//   req_ready     out  NREQ     one-hot accept; bit i high only when granted
//   req_op        in   3*NREQ   op per requester, slice i = [3i+2:3i]
//   req_a         in   4*NREQ   operand a per requester
//   req_b         in   4*NREQ   operand b per requester
//   alu_a         out  4        to ALU a
//   alu_b         out  4        to ALU b (already inverted for ops 001/110/111)
//   alu_c         out  3        to ALU function select
//   alu_cin       out  1        to ALU carry-in
//   alu_result    in   4        from ALU
//   alu_overflow  in   1        from ALU
//   alu_carry     in   1        from ALU
//   rsp_valid     out  1        response valid
//   rsp_ready     in   1        response consumer ready
//   rsp_id        out  IDW      index of requester that issued the command
//   rsp_result    out  4        captured result
//   rsp_flags     out  4        {zero, overflow, carry, cmp}
// BEHAVIOUR
//   - Clock and reset: single clock clk; rst_n is asynchronous, active-low.
//   - Reset: state=IDLE, all outputs 0, rr pointer = NREQ-1, so requester 0
//     wins first.
//   - FSM states: IDLE -> ISSUE -> (WAIT x ALU_WAIT) -> CAPTURE -> RESP -> IDLE.
//   - IDLE: if any req_valid, grant the first valid index after the rr pointer
//     (circular), combinationally assert that req_ready bit, register
//     op/a/b/id, update rr pointer to the granted index, go to ISSUE.
//   - req_ready is 0 in every state other than IDLE; at most one bit is ever high.
//   - ALU drive, registered, stable from ISSUE through CAPTURE, 0 in IDLE:
//     - ops 000, 010..101: alu_b = b, alu_cin = 0.
//     - ops 001, 110, 111: alu_b = ~b, alu_cin = 1.
//     - alu_c = op.
//   - CAPTURE: register alu_result and flags, go to RESP.
//   - Flags, computed by this block:
//     - zero = (result == 0), for all ops.
//     - overflow = alu_overflow for 000/001/110/111, else 0.
//     - carry = alu_carry for 000/001/110/111, else 0.
//     - cmp = result[3] ^ overflow (signed a<b) for 110; zero (a==b) for 111;
//       0 otherwise.
//   - RESP: rsp_valid = 1 with rsp_* held stable until rsp_valid & rsp_ready
//     at a clock edge, then IDLE. A new grant is possible in the cycle after
//     that edge (no overlap).
//   - Latency with ALU_WAIT = 0 and rsp_ready = 1: accept edge E0; rsp_valid
//     high after E2; handshake at E3. Throughput is 1 command per 4 cycles.
//   - rsp_ready low stalls indefinitely. Requesters simply keep req_valid
//     high; no command is dropped or duplicated.
//   - Reset mid-operation: the in-flight command is discarded with no
//     response, and all outputs return to their reset values immediately.
//   - Unused ALU outputs (zero/size) are ignored.
// TESTING
//   1. req0: op 000, a=7, b=9 -> alu_b=9, cin=0; rsp result=0, flags=1010,
//      id=0.
//   2. req1: op 001, a=3, b=5 -> alu_b=1010, cin=1; rsp result=1110,
//      flags=0000, id=1.
//   3. op 110, a=2, b=6 -> result=1100, cmp=1.
//      op 111, a=5, b=5 -> result=0, flags=1011 (zero=1, carry=1, cmp=1).
//   4. Both req_valid held high for 6 commands -> grants alternate 0,1,0,1,...;
//      req_ready is never 2'b11.
//   5. rsp_ready low for 10 cycles in RESP -> rsp_* stable, req_ready=0
//      throughout; one response on release.
//   6. rst_n pulled low in ISSUE -> alu_* and rsp_valid are 0 asynchronously;
//      after release, first grant goes to req0.

Source files
------------

// File: rtl/alu4_arbiter_seq_if.sv
// Bundle of the request, ALU-drive and response signals of alu4_arbiter_seq.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface alu4_arbiter_seq_if #(
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_c;
    logic              alu_cin;
    logic [3:0]        alu_result;
    logic              alu_overflow;
    logic              alu_carry;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_result;
    logic [3:0]        rsp_flags;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_overflow, alu_carry, rsp_ready,
        output req_ready, alu_a, alu_b, alu_c, alu_cin,
        output rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_overflow, alu_carry, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_c, alu_cin,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu4_arbiter_seq.sv
// Round-robin arbiter sharing one combinational 4-bit ALU between NREQ
// requesters. One command in flight at a time: IDLE -> ISSUE -> WAIT* ->
// CAPTURE -> RESP. Subtract/compare ops get b pre-inverted and cin = 1.
module alu4_arbiter_seq #(
    parameter int NREQ     = 2,
    parameter int ALU_WAIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    alu4_arbiter_seq_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [2:0]      wait_q, wait_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_c_q, alu_c_d;
    logic            alu_cin_q, alu_cin_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [3:0]      rsp_result_q, rsp_result_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;

    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] req_ready;

    // Circular search for the first valid requester after the rr pointer.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // Next-state, command latch, ALU drive and result/flag capture.
    always_comb begin
        int         gi;
        logic [2:0] op;
        logic [3:0] b;
        logic       sub;
        logic       arith;
        logic       zero;
        logic       ovf;
        logic       cry;
        logic       cmp;

        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        wait_d       = wait_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_c_d      = alu_c_q;
        alu_cin_d    = alu_cin_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        req_ready    = '0;

        gi  = int'(grant_idx);
        op  = bus.req_op[gi*3 +: 3];
        b   = bus.req_b[gi*4 +: 4];
        sub = (op == 3'b001) || (op[2:1] == 2'b11);

        // Overflow/carry only mean something for the adder ops.
        arith = (alu_c_q == 3'b000) || (alu_c_q == 3'b001) || (alu_c_q[2:1] == 2'b11);
        zero  = (bus.alu_result == 4'd0);
        ovf   = arith & bus.alu_overflow;
        cry   = arith & bus.alu_carry;
        cmp   = (alu_c_q == 3'b110) ? (bus.alu_result[3] ^ ovf) :
                (alu_c_q == 3'b111) ? zero : 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[gi] = 1'b1;
                    rr_d          = grant_idx;
                    id_d          = grant_idx;
                    alu_a_d       = bus.req_a[gi*4 +: 4];
                    alu_b_d       = sub ? ~b : b;
                    alu_c_d       = op;
                    alu_cin_d     = sub;
                    wait_d        = '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                wait_d  = '0;
                state_d = (ALU_WAIT == 0) ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (int'(wait_q) >= ALU_WAIT - 1) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            CAPTURE: begin
                rsp_id_d     = id_q;
                rsp_result_d = bus.alu_result;
                rsp_flags_d  = {zero, ovf, cry, cmp};
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    alu_c_d   = '0;
                    alu_cin_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= IDW'(NREQ - 1);
            id_q         <= '0;
            wait_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_c_q      <= '0;
            alu_cin_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            wait_q       <= wait_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_c_q      <= alu_c_d;
            alu_cin_q    <= alu_cin_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_c      = alu_c_q;
    assign bus.alu_cin    = alu_cin_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
endmodule
